// File: rtl/exception_unit_pkg.sv
// Shared CP0 definitions for the exception unit: CP0 write indices
// ({reg[4:0], sel[2:0]}), ExcCode values and the Status.EXL bit position.
package exception_unit_pkg;

  // CP0 write indices, encoded as {reg[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = 8'h40;  // {8,0}
  localparam logic [7:0] CP0_STATUS   = 8'h60;  // {12,0}
  localparam logic [7:0] CP0_CAUSE    = 8'h68;  // {13,0}
  localparam logic [7:0] CP0_EPC      = 8'h70;  // {14,0}

  // ExcCode values
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status.EXL bit position
  localparam int STATUS_EXL = 1;

  // Address-error exceptions are the only ones that report a BadVAddr
  function automatic logic needs_badvaddr(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exception_unit.sv
// Exception unit: sequences CP0 register writes for an exception or ERET
// through CP0's single write port, stalls the pipeline while doing so, then
// issues a one-cycle flush with a redirect PC.
// Optional feature macro: EXC_BADVADDR_EN (adds the BadVAddr write for
// address-error exceptions).
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [31:0] status_in,
  input  logic [31:0] cause_in,
  input  logic [31:0] epc_in,
  output logic        cp0_wenable,
  output logic [7:0]  cp0_widx,
  output logic [31:0] cp0_wdata,
  output logic        stall,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    WR_EPC,
    WR_CAUSE,
`ifdef EXC_BADVADDR_EN
    WR_BADV,
`endif
    WR_STATUS,
    ERET_WR,
    REDIRECT
  } state_e;

  state_e      state_q;
  logic [4:0]  code_q;
  logic        bd_q;
  logic [31:0] epc_q;     // EPC to write (exception) or redirect target (ERET)
  logic        is_eret_q;
`ifdef EXC_BADVADDR_EN
  logic [31:0] badv_q;
`endif

  // Cause bits replaced by the write (BD, ExcCode) are never read from cause_in
  logic unused_in;
`ifdef EXC_BADVADDR_EN
  assign unused_in = ^{cause_in[31], cause_in[6:2]};
`else
  assign unused_in = ^{cause_in[31], cause_in[6:2], exc_badvaddr};
`endif

  // FSM: capture the request in IDLE, then walk the CP0 write sequence
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      bd_q      <= 1'b0;
      epc_q     <= '0;
      is_eret_q <= 1'b0;
`ifdef EXC_BADVADDR_EN
      badv_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (exc_valid) begin
            // Exception wins over a simultaneous ERET
            code_q    <= exc_code;
            bd_q      <= exc_bd;
            epc_q     <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            is_eret_q <= 1'b0;
`ifdef EXC_BADVADDR_EN
            badv_q    <= exc_badvaddr;
`endif
            // Nested exception (EXL already set) keeps the original EPC
            state_q   <= status_in[STATUS_EXL] ? WR_CAUSE : WR_EPC;
          end else if (eret) begin
            epc_q     <= epc_in;
            is_eret_q <= 1'b1;
            state_q   <= ERET_WR;
          end
        end
        WR_EPC:    state_q <= WR_CAUSE;
`ifdef EXC_BADVADDR_EN
        WR_CAUSE:  state_q <= needs_badvaddr(code_q) ? WR_BADV : WR_STATUS;
        WR_BADV:   state_q <= WR_STATUS;
`else
        WR_CAUSE:  state_q <= WR_STATUS;
`endif
        WR_STATUS: state_q <= REDIRECT;
        ERET_WR:   state_q <= REDIRECT;
        REDIRECT:  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Write mux, stall and redirect decoded from the current state
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    cp0_wenable = 1'b0;
    cp0_widx    = '0;
    cp0_wdata   = '0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = '0;
    case (state_q)
      IDLE: stall = exc_valid | eret;
      WR_EPC: begin
        cp0_wenable = 1'b1;
        cp0_widx    = CP0_EPC;
        cp0_wdata   = epc_q;
        stall       = 1'b1;
      end
      WR_CAUSE: begin
        cp0_wenable = 1'b1;
        cp0_widx    = CP0_CAUSE;
        cp0_wdata   = {bd_q, cause_in[30:7], code_q, cause_in[1:0]};
        stall       = 1'b1;
      end
`ifdef EXC_BADVADDR_EN
      WR_BADV: begin
        cp0_wenable = 1'b1;
        cp0_widx    = CP0_BADVADDR;
        cp0_wdata   = badv_q;
        stall       = 1'b1;
      end
`endif
      WR_STATUS: begin
        cp0_wenable = 1'b1;
        cp0_widx    = CP0_STATUS;
        cp0_wdata   = status_in | (32'd1 << STATUS_EXL);
        stall       = 1'b1;
      end
      ERET_WR: begin
        cp0_wenable = 1'b1;
        cp0_widx    = CP0_STATUS;
        cp0_wdata   = status_in & ~(32'd1 << STATUS_EXL);
        stall       = 1'b1;
      end
      REDIRECT: begin
        flush       = 1'b1;
        redirect_pc = is_eret_q ? epc_q : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// Testbench for exception_unit: directed scenarios plus randomized
// exception/ERET traffic. A reference model pushes the expected CP0 writes
// and flush (with their cycle numbers) into a queue; a monitor pops and
// compares whenever the DUT writes CP0 or flushes.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic        cp0_wenable;
  logic [7:0]  cp0_widx;
  logic [31:0] cp0_wdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;

  exception_unit dut (
    .clk          (clk),
    .rst          (rst),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .status_in    (status_in),
    .cause_in     (cause_in),
    .epc_in       (epc_in),
    .cp0_wenable  (cp0_wenable),
    .cp0_widx     (cp0_widx),
    .cp0_wdata    (cp0_wdata),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_flush;
    logic [7:0]  idx;
    logic [31:0] data;   // write data, or redirect PC for a flush
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: the list of CP0 writes and the final flush an exception causes
  task automatic model_exc(input int n, input logic [4:0] code, input logic [31:0] pc,
                           input logic bd, input logic [31:0] bva,
                           input logic [31:0] status, input logic [31:0] cause,
                           output int len);
    int c = n + 1;
    logic [31:0] cw;
    if (status[1] == 1'b0) begin
      exp_q.push_back('{c, 1'b0, 8'h70, bd ? pc - 32'd4 : pc});
      c++;
    end
    cw = cause;
    cw[31] = bd;
    cw[6:2] = code;
    exp_q.push_back('{c, 1'b0, 8'h68, cw});
    c++;
`ifdef EXC_BADVADDR_EN
    if (code == 5'd4 || code == 5'd5) begin
      exp_q.push_back('{c, 1'b0, 8'h40, bva});
      c++;
    end
`else
    if (bva === 32'hx) c = c;  // BadVAddr is never written in this build
`endif
    exp_q.push_back('{c, 1'b0, 8'h60, status | 32'h2});
    c++;
    exp_q.push_back('{c, 1'b1, 8'h00, 32'h8000_0180});
    len = c - n;
  endtask

  task automatic model_eret(input int n, input logic [31:0] status,
                            input logic [31:0] epc, output int len);
    exp_q.push_back('{n + 1, 1'b0, 8'h60, status & ~32'h2});
    exp_q.push_back('{n + 2, 1'b1, 8'h00, epc});
    len = 2;
  endtask

  task automatic idle_inputs();
    exc_valid = 1'b0;
    eret      = 1'b0;
  endtask

  // Present one request for one cycle; noise pulses the request inputs
  // while the sequence runs; rst_k>0 asserts reset during cycle N+rst_k.
  task automatic issue(input bit v, input bit e, input logic [4:0] code,
                       input logic [31:0] pc, input logic bd, input logic [31:0] bva,
                       input logic [31:0] status, input logic [31:0] cause,
                       input logic [31:0] epc, input bit noise, input int rst_k);
    int n;
    int len;
    @(posedge clk);
    #1;
    exc_valid    = v;
    eret         = e;
    exc_code     = code;
    exc_pc       = pc;
    exc_bd       = bd;
    exc_badvaddr = bva;
    status_in    = status;
    cause_in     = cause;
    epc_in       = epc;
    n = cyc;
    if (v) model_exc(n, code, pc, bd, bva, status, cause, len);
    else model_eret(n, status, epc, len);
    if (rst_k > 0)
      while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > n + rst_k) void'(exp_q.pop_back());
    #1;
    check("stall_on_request", stall === 1'b1, $sformatf("stall=%b want 1", stall));
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (rst_k > 0) begin
        rst = (k == rst_k);
        idle_inputs();
      end else if (noise) begin
        exc_valid    = 1'($urandom);
        eret         = 1'($urandom);
        exc_code     = 5'($urandom);
        exc_pc       = $urandom;
        exc_bd       = 1'($urandom);
        exc_badvaddr = $urandom;
      end else begin
        idle_inputs();
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  // Monitor: compare every CP0 write / flush against the head of the queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (cp0_wenable === 1'b1 || flush === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b0,
                $sformatf("cyc %0d we=%b idx=%h data=%h flush=%b pc=%h, want none",
                          cyc, cp0_wenable, cp0_widx, cp0_wdata, flush, redirect_pc));
        end else begin
          ev_t e;
          bit ok;
          e = exp_q.pop_front();
          if (e.is_flush)
            ok = (e.cyc == cyc) && flush === 1'b1 && cp0_wenable === 1'b0 &&
                 redirect_pc === e.data && stall === 1'b0;
          else
            ok = (e.cyc == cyc) && cp0_wenable === 1'b1 && flush === 1'b0 &&
                 cp0_widx === e.idx && cp0_wdata === e.data && stall === 1'b1;
          check(e.is_flush ? "flush" : "cp0_write", ok,
                $sformatf("cyc %0d we=%b idx=%h data=%h flush=%b pc=%h stall=%b; want cyc %0d flush=%b idx=%h data/pc=%h",
                          cyc, cp0_wenable, cp0_widx, cp0_wdata, flush, redirect_pc, stall,
                          e.cyc, e.is_flush, e.idx, e.data));
        end
      end else begin
        bit missed;
        missed = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
        if (missed) void'(exp_q.pop_front());
        check("quiet_cycle", !missed && cp0_widx === 8'h00 && cp0_wdata === 32'h0,
              $sformatf("cyc %0d missed_event=%b idx=%h data=%h, want no event and zeros",
                        cyc, missed, cp0_widx, cp0_wdata));
      end
    end
  end

  initial begin
    logic [4:0] codes [4];
    codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd8; codes[3] = 5'd12;

    rst = 1'b1;
    idle_inputs();
    exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
    status_in = '0; cause_in = '0; epc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {cp0_wenable, cp0_widx, cp0_wdata, stall, flush, redirect_pc} === '0,
          $sformatf("we=%b idx=%h data=%h stall=%b flush=%b pc=%h, want all 0",
                    cp0_wenable, cp0_widx, cp0_wdata, stall, flush, redirect_pc));
    mon_en = 1'b1;

    // 1: plain exception, EXL=0
    issue(1, 0, 5'd12, 32'h8000_1000, 0, 32'h0, 32'h0000_0000, 32'h0000_0000, 32'h0, 0, 0);
    // 2: branch delay slot
    issue(1, 0, 5'd12, 32'h8000_1004, 1, 32'h0, 32'h0000_0000, 32'h0000_0000, 32'h0, 0, 0);
    // 3: nested exception, EXL=1
    issue(1, 0, 5'd8, 32'h8000_1100, 0, 32'h0, 32'h0000_0003, 32'h0000_0000, 32'h0, 0, 0);
    // 4: ERET
    issue(0, 1, 5'd0, 32'h0, 0, 32'h0, 32'h0000_0003, 32'h0, 32'h8000_2000, 0, 0);
    // 5: exception and ERET together, with mid-sequence request pulses
    issue(1, 1, 5'd12, 32'h8000_3000, 0, 32'h0, 32'h0000_ff00, 32'h1234_5678, 32'hdead_beec, 1, 0);
    // 6: address error with BadVAddr, reset during the second write
    issue(1, 0, 5'd4, 32'h8000_4000, 0, 32'h8000_0003, 32'h0, 32'h0, 32'h0, 0, 2);
    issue(1, 0, 5'd5, 32'h8000_5000, 1, 32'h1234_0002, 32'h0, 32'h0, 32'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      bit v, e;
      logic [31:0] st;
      int sel;
      sel = int'($urandom_range(0, 4));
      v = (sel != 0);
      e = (sel == 0) || (sel == 4);
      st = $urandom;
      st[1] = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(v, e, ($urandom_range(0, 3) == 0) ? 5'($urandom) : codes[$urandom_range(0, 3)],
            {$urandom} & 32'hffff_fffc, 1'($urandom), $urandom, st, $urandom, $urandom,
            1'($urandom), 0);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size() == 0,
          $sformatf("%0d expected events outstanding, want 0", exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
